// File: rtl/conv2d_psum_collector.sv
// Collects per-row partial sums from the PE lanes, aligns them per output
// pixel, adds them and streams each finished pixel out over ready/valid.
module conv2d_psum_collector #(
  parameter int DWIDTH     = 32,
  parameter int WT_DIM     = 3,
  parameter int LANE_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DWIDTH-1:0]        fm_dim,
  input  logic [WT_DIM*DWIDTH-1:0] pe_data_i,
  input  logic [WT_DIM-1:0]        pe_valid_i,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int AW = $clog2(LANE_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [DWIDTH-1:0] CNT_ONE = DWIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nx;

  logic [DWIDTH-1:0] mem [WT_DIM][LANE_DEPTH];
  logic [AW:0]       wr_ptr [WT_DIM];
  logic [AW:0]       rd_ptr [WT_DIM];
  logic [WT_DIM-1:0] empty, full, push, drop;
  logic [DWIDTH-1:0] total, out_cnt, sum;
  logic              run, start_ok, take, last, fire;

  assign run      = state == S_RUN;
  assign start_ok = (state == S_IDLE) && start;
  assign take     = out_valid && out_ready;
  assign last     = run && take && (out_cnt == total - CNT_ONE);
  // The final handshake closes the layer; surplus heads are never popped.
  assign fire     = run && ~|empty && (!out_valid || out_ready) && !last;
  assign busy     = run;
  assign done     = state == S_DONE;

  always_comb begin
    empty = '0;
    full  = '0;
    sum   = '0;
    for (int i = 0; i < WT_DIM; i++) begin
      empty[i] = wr_ptr[i] == rd_ptr[i];
      full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                 (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      sum      = sum + mem[i][rd_ptr[i][AW-1:0]];
    end
  end

  always_comb begin
    push = '0;
    drop = '0;
    for (int i = 0; i < WT_DIM; i++) begin
      push[i] = run && pe_valid_i[i] && (!full[i] || fire);
      drop[i] = run && pe_valid_i[i] && full[i] && !fire;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = (fm_dim != '0) ? S_RUN : S_DONE;
      S_RUN:  if (last) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total     <= '0;
      out_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < WT_DIM; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      if (start_ok) begin
        total    <= fm_dim * fm_dim;
        out_cnt  <= '0;
        overflow <= 1'b0;
        for (int i = 0; i < WT_DIM; i++) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
        end
      end else begin
        if (last)
          out_cnt <= '0;
        else if (run && take)
          out_cnt <= out_cnt + CNT_ONE;
        if (|drop) overflow <= 1'b1;
        for (int i = 0; i < WT_DIM; i++) begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
          if (fire)    rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
        end
      end
      if (fire) begin
        out_data  <= sum;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WT_DIM; i++)
      if (push[i])
        mem[i][wr_ptr[i][AW-1:0]] <= pe_data_i[i*DWIDTH +: DWIDTH];
  end

endmodule

// File: tb/tb_conv2d_psum_collector.sv
// Bench for conv2d_psum_collector: vector table, hand sequences and
// randomized layers checked against a per-pixel lane-sum reference.
module tb_conv2d_psum_collector;

  localparam int DW = 32;
  localparam int WD = 3;
  localparam int LD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] fm_dim = '0;
  logic [WD*DW-1:0] pe_data = '0;
  logic [WD-1:0] pe_valid = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy, done, overflow;

  conv2d_psum_collector #(.DWIDTH(DW), .WT_DIM(WD), .LANE_DEPTH(LD)) dut (
    .clk(clk), .rst(rst_n), .start(start), .fm_dim(fm_dim),
    .pe_data_i(pe_data), .pe_valid_i(pe_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 0;
  logic [31:0] expq [$];
  logic [31:0] ld [WD][64];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mon_en && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_out: got %0h want none", out_data);
      end else begin
        check("out_seq", out_data, expq.pop_front());
      end
    end
  endtask

  task automatic start_layer(input int fm);
    start  = 1'b1;
    fm_dim = fm;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < 40) begin
      tick();
      t++;
    end
    check(name, done, 1'b1);
  endtask

  task automatic run_layer(input int fm, input int skew, input int rmode,
                           input bit rpush);
    int n, c, acc;
    int pushed [WD];
    logic [31:0] expv [64];
    logic [31:0] prev_data;
    bit prev_hold, l2seen, l2now, rdy;
    int pat [4] = '{1, 0, 0, 1};
    n = fm * fm;
    for (int k = 0; k < n; k++)
      expv[k] = ld[0][k] + ld[1][k] + ld[2][k];
    for (int i = 0; i < WD; i++) pushed[i] = 0;
    acc = 0; c = 0; prev_hold = 0; l2seen = 0; prev_data = '0;
    mon_en = 0;
    out_ready = 1'b0;
    start_layer(fm);
    check("busy_run", busy, 1'b1);
    while (acc < n && c < 4000) begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, prev_data);
      end
      if (!l2seen) check("early_out", out_valid, 1'b0);
      case (rmode)
        0: rdy = 1'b1;
        1: rdy = pat[c % 4] != 0;
        default: rdy = $urandom_range(0, 1) != 0;
      endcase
      if (out_valid && rdy) begin
        check("out_model", out_data, expv[acc]);
        acc++;
      end
      prev_hold = out_valid && !rdy;
      prev_data = out_data;
      pe_valid = '0;
      pe_data  = '0;
      l2now    = 0;
      for (int i = 0; i < WD; i++) begin
        if (pushed[i] < n && c >= ((i == 2) ? skew : 0) &&
            (pushed[i] - acc) < LD - 1 &&
            (!rpush || $urandom_range(0, 1) != 0)) begin
          pe_valid[i] = 1'b1;
          pe_data[i*DW +: DW] = ld[i][pushed[i]];
          pushed[i]++;
          if (i == 2) l2now = 1;
        end
      end
      out_ready = rdy;
      tick();
      if (l2now) l2seen = 1;
      c++;
    end
    pe_valid = '0;
    if (acc < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL layer_timeout: got %0d outputs want %0d", acc, n);
    end
    check("done_pulse", done, 1'b1);
    check("busy_fall", busy, 1'b0);
    check("no_overflow", overflow, 1'b0);
    out_ready = 1'b1;
    tick();
    check("done_single", done, 1'b0);
  endtask

  initial begin
    tbl[0] = '{32'd1, 32'd10, 32'd100, 32'd111};
    tbl[1] = '{32'd2, 32'd20, 32'd200, 32'd222};
    tbl[2] = '{32'd3, 32'd30, 32'd300, 32'd333};
    tbl[3] = '{32'd4, 32'd40, 32'd400, 32'd444};
    tbl[4] = '{32'hFFFFFFFF, 32'h2, 32'h0, 32'h1};
    tbl[5] = '{32'h80000000, 32'h80000000, 32'h5, 32'h5};
    tbl[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[7] = '{32'h7, 32'h0, 32'h0, 32'h7};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_data", out_data, '0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // table vectors: two lockstep layers of four pixels
    for (int g = 0; g < 2; g++) begin
      out_ready = 1'b1;
      start_layer(2);
      check("tbl_busy", busy, 1'b1);
      expq.delete();
      mon_en = 1;
      for (int k = 0; k < 4; k++) begin
        expq.push_back(tbl[4*g+k].exp);
        pe_valid = 3'b111;
        pe_data = {tbl[4*g+k].c, tbl[4*g+k].b, tbl[4*g+k].a};
        tick();
      end
      pe_valid = '0;
      wait_done("tbl_done");
      check("tbl_drained", expq.size(), 0);
      check("tbl_busy_fall", busy, 1'b0);
      tick();
      check("tbl_done_once", done, 1'b0);
      mon_en = 0;
    end

    // skewed arrival with toggling backpressure
    for (int k = 0; k < 4; k++) begin
      ld[0][k] = k + 1;
      ld[1][k] = 10 * (k + 1);
      ld[2][k] = 100 * (k + 1);
    end
    run_layer(2, 5, 1, 0);

    // overflow: lane0 overfilled while lane1 stays empty
    out_ready = 1'b1;
    start_layer(3);
    expq.delete();
    for (int k = 1; k <= 8; k++) expq.push_back(k);
    expq.push_back(32'd100);
    mon_en = 1;
    for (int k = 1; k <= 9; k++) begin
      pe_valid = 3'b001;
      pe_data = '0;
      pe_data[DW-1:0] = k;
      tick();
      if (k == 8) check("ovf_before", overflow, 1'b0);
      if (k == 9) check("ovf_after", overflow, 1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      pe_valid = 3'b110;
      pe_data = '0;
      tick();
    end
    pe_valid = 3'b111;
    pe_data = '0;
    pe_data[DW-1:0] = 32'd100;
    tick();
    pe_valid = '0;
    wait_done("ovf_done");
    check("ovf_drained", expq.size(), 0);
    check("ovf_sticky", overflow, 1'b1);
    tick();
    mon_en = 0;

    // fm_dim = 0 goes straight to done; its start also clears overflow
    start_layer(0);
    check("z_done", done, 1'b1);
    check("z_ovf_clr", overflow, 1'b0);
    check("z_busy", busy, 1'b0);
    check("z_valid", out_valid, 1'b0);
    tick();
    check("z_done_once", done, 1'b0);
    check("z_valid2", out_valid, 1'b0);

    // reset during RUN with entries queued
    out_ready = 1'b0;
    start_layer(2);
    for (int k = 1; k <= 3; k++) begin
      pe_valid = 3'b111;
      pe_data = {32'd900 + k, 32'd90 + k, 32'd9 + k};
      tick();
    end
    pe_valid = '0;
    tick();
    check("pre_rst_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_layer(2, 0, 0, 0);

    // randomized layers
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < WD; i++)
        for (int k = 0; k < 64; k++)
          ld[i][k] = $urandom;
      run_layer($urandom_range(1, 5), $urandom_range(0, 6), 2, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
